// File: rtl/ro_freq_meter.sv
`timescale 1ns/1ps
// ro_freq_meter: a bank of NUM_CH enable-gated inverter rings (odd stage counts), one of which
// is run at a time, pre-divided, synchronised into clk and edge-counted over a fixed gate window.
module ro_freq_meter #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned BASE_STAGES  = 3,
    parameter int unsigned INV_DELAY_ns = 2,
    parameter int unsigned DIV_LOG2     = 4,
    parameter int unsigned GATE_LOG2    = 10,
    parameter int unsigned SETTLE_CYC   = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          count,
    output logic                      overflow,
    output logic                      osc_div
);

    localparam int unsigned CH_W     = $clog2(NUM_CH);
    localparam int unsigned GATE_CYC = 2 ** GATE_LOG2;
    localparam int unsigned TMR_MAX  = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX) + 1;

    typedef enum logic [1:0] {StIdle, StSettle, StGate, StDone} state_t;

    state_t             r_state;
    logic [CH_W-1:0]    r_ch;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_int;
    logic               r_ring_en;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic [DIV_LOG2-1:0] r_div;
    logic               r_sync1, r_sync2, r_sync3;

    logic [NUM_CH-1:0]  w_tail;
    logic [NUM_CH-1:0]  w_en;
    logic               w_osc;
    logic               w_div_rst_n;
    logic               w_edge;
    logic [CH_W-1:0]    w_ch_cap;

    // Ring bank: stage 0 is NAND(enable, tail); a disabled ring rests with every odd stage
    // count leaving the tail at 1, so the selection mux never sees a spurious edge.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ring
        localparam int unsigned STAGES = BASE_STAGES + 2 * c;
        logic [STAGES-1:0] w_stage;

        assign w_en[c] = r_ring_en && (r_ch == CH_W'(c));

        for (genvar k = 0; k < STAGES; k++) begin : g_inv
            if (k == 0) begin : g_nand
`ifdef SYNTHESIS
                assign w_stage[0] = ~(w_en[c] & w_stage[STAGES-1]);
`else
                assign #(INV_DELAY_ns) w_stage[0] = ~(w_en[c] & w_stage[STAGES-1]);
`endif
            end else begin : g_not
`ifdef SYNTHESIS
                assign w_stage[k] = ~w_stage[k-1];
`else
                assign #(INV_DELAY_ns) w_stage[k] = ~w_stage[k-1];
`endif
            end
        end

        assign w_tail[c] = w_stage[STAGES-1];
    end

    assign w_osc       = w_tail[r_ch];
    assign w_div_rst_n = rst_n & r_ring_en;
    assign osc_div     = r_div[DIV_LOG2-1];

    // Out-of-range selections fall back to the longest ring.
    assign w_ch_cap = (32'(ch_sel) >= NUM_CH) ? CH_W'(NUM_CH - 1) : ch_sel;

    // Pre-divider in the ring clock domain, held cleared whenever the ring is off.
    always_ff @(posedge w_osc or negedge w_div_rst_n) begin
        if (!w_div_rst_n) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Two-flop synchroniser plus edge-detect flop for the divided oscillator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= osc_div;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync3;

    // Measurement sequencer: settle, gate-count, publish result; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_ch       <= '0;
            r_timer    <= '0;
            r_cnt      <= '0;
            r_ovf_int  <= 1'b0;
            r_ring_en  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_ch      <= w_ch_cap;
                        r_cnt     <= '0;
                        r_ovf_int <= 1'b0;
                        r_timer   <= '0;
                        r_ring_en <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= StSettle;
                    end
                end
                StSettle: begin
                    if (r_timer == TMR_W'(SETTLE_CYC - 1)) begin
                        r_timer <= '0;
                        r_state <= StGate;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StGate: begin
                    if (w_edge) begin
                        if (r_cnt == {CNT_W{1'b1}}) begin
                            r_ovf_int <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    if (r_timer == TMR_W'(GATE_CYC - 1)) begin
                        r_ring_en <= 1'b0;
                        r_state   <= StDone;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                StDone: begin
                    r_count    <= r_cnt;
                    r_overflow <= r_ovf_int;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_ro_freq_meter.sv
`timescale 1ns/1ps
// Bench for ro_freq_meter: two instances (default, and a 3-channel 4-bit-count short-gate one)
// checked every cycle against a run-level model built from ring period arithmetic.
module tb_ro_freq_meter;

    localparam int TCLK = 10;
    localparam int INV  = 2;
    localparam int DIV  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic       start_v [2];
    logic [1:0] sel_v   [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic       ovf_v   [2];
    logic       osc_v   [2];
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    int          ocnt [2];

    always #5 clk = ~clk;

    ro_freq_meter dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .ch_sel(sel_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .count(cnt_a), .overflow(ovf_v[0]),
        .osc_div(osc_v[0])
    );

    ro_freq_meter #(.NUM_CH(3), .GATE_LOG2(9), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .ch_sel(sel_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .count(cnt_b), .overflow(ovf_v[1]),
        .osc_div(osc_v[1])
    );

    always_comb begin
        ocnt[0] = int'(cnt_a);
        ocnt[1] = int'(cnt_b);
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        n_chk++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, got, lo, hi, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic int p_nch(input int d);  return (d == 0) ? 4 : 3;        endfunction
    function automatic int p_gate(input int d); return (d == 0) ? 1024 : 512;   endfunction
    function automatic int p_max(input int d);  return (d == 0) ? 65535 : 15;   endfunction
    function automatic int p_lat(input int d);  return 16 + p_gate(d) + 1;      endfunction

    function automatic int clamp(input int d, input int ch);
        return (ch >= p_nch(d)) ? p_nch(d) - 1 : ch;
    endfunction

    // Whole divided periods that fit in the gate window.
    function automatic int ideal(input int d, input int ch);
        int st;
        st = 3 + 2 * clamp(d, ch);
        return (p_gate(d) * TCLK) / (2 * st * INV * DIV);
    endfunction

    int cyc = 0;
    bit m_act     [2] = '{1'b0, 1'b0};
    int m_s       [2] = '{0, 0};
    int m_ch      [2] = '{0, 0};
    int m_done_at [2] = '{-10, -10};
    int m_lo      [2] = '{0, 0};
    int m_hi      [2] = '{0, 0};
    bit m_ovf     [2] = '{1'b0, 1'b0};
    bit m_ovf_chk [2] = '{1'b1, 1'b1};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_act[d]     <= 1'b0;
                m_done_at[d] <= -10;
                m_lo[d]      <= 0;
                m_hi[d]      <= 0;
                m_ovf[d]     <= 1'b0;
                m_ovf_chk[d] <= 1'b1;
            end
        end else begin
            cyc <= cyc + 1;
            for (int d = 0; d < 2; d++) begin
                if (m_act[d]) begin
                    if (cyc + 1 == m_s[d] + p_lat(d)) begin
                        m_act[d]     <= 1'b0;
                        m_done_at[d] <= cyc + 1;
                        m_lo[d]      <= (ideal(d, m_ch[d]) - 1 > p_max(d)) ? p_max(d)
                                        : ideal(d, m_ch[d]) - 1;
                        m_hi[d]      <= (ideal(d, m_ch[d]) + 1 > p_max(d)) ? p_max(d)
                                        : ideal(d, m_ch[d]) + 1;
                        m_ovf[d]     <= (ideal(d, m_ch[d]) - 1 > p_max(d));
                        m_ovf_chk[d] <= (ideal(d, m_ch[d]) - 1 > p_max(d)) ||
                                        (ideal(d, m_ch[d]) + 1 <= p_max(d));
                    end
                end else if (start_v[d]) begin
                    m_act[d] <= 1'b1;
                    m_s[d]   <= cyc + 1;
                    m_ch[d]  <= int'(sel_v[d]);
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("busy%0d", d), int'(busy_v[d]), int'(m_act[d]));
            chk($sformatf("done%0d", d), int'(done_v[d]), int'(rst_n && cyc == m_done_at[d]));
            chk_rng($sformatf("count%0d", d), ocnt[d], m_lo[d], m_hi[d]);
            if (m_ovf_chk[d]) chk($sformatf("overflow%0d", d), int'(ovf_v[d]), int'(m_ovf[d]));
            if (!m_act[d]) chk($sformatf("osc_div_idle%0d", d), int'(osc_v[d]), 0);
        end
        if (m_act[0])
            for (int c = 0; c < 4; c++)
                if (c != clamp(0, m_ch[0])) chk("ring_idle_a", int'(dut_a.w_tail[c]), 1);
        if (m_act[1])
            for (int c = 0; c < 3; c++)
                if (c != clamp(1, m_ch[1])) chk("ring_idle_b", int'(dut_b.w_tail[c]), 1);
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int d, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (done_v[d]) return;
        end
        chk($sformatf("done_timeout%0d", d), 0, 1);
    endtask

    task automatic do_run(input int d, input int sel, output int lat);
        @(negedge clk);
        start_v[d] = 1'b1;
        sel_v[d]   = 2'(sel);
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        wait_done(d, 3000, lat);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_low;
        start_v[0] = 1'b1; start_v[1] = 1'b1;
        sel_v[0]   = 2'd0; sel_v[1]   = 2'd0;

        // Reset with start held: everything stays at zero, no done afterwards.
        repeat (5) @(negedge clk);
        chk("reset_tails_a", int'(dut_a.w_tail), 15);
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Channel 0 and channel 3 on the default instance.
        do_run(0, 0, lat);
        chk("latency_a", lat, 1041);
        chk_rng("count_ch0", int'(cnt_a), 52, 54);
        chk("ovf_ch0", int'(ovf_v[0]), 0);
        do_run(0, 3, lat);
        chk_rng("count_ch3", int'(cnt_a), 16, 18);

        // Mid-run start pulse and ch_sel change are ignored.
        @(negedge clk);
        start_v[0] = 1'b1; sel_v[0] = 2'd1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (500) @(negedge clk);
        start_v[0] = 1'b1; sel_v[0] = 2'd3;
        @(negedge clk);
        start_v[0] = 1'b0; sel_v[0] = 2'd0;
        wait_done(0, 1200, lat);
        chk_rng("count_captured_ch1", int'(cnt_a), 31, 33);

        // start held high: back-to-back runs, busy low for exactly one cycle between them.
        @(negedge clk);
        start_v[0] = 1'b1; sel_v[0] = 2'd2;
        n_low = 0;
        repeat (2600) begin
            @(negedge clk);
            if (!busy_v[0]) n_low++;
        end
        start_v[0] = 1'b0;
        chk("busy_low_cycles", n_low, 2);
        wait_done(0, 1200, lat);

        // Saturating instance: overflow, then a valid run clears it (ch_sel 3 -> channel 2).
        do_run(1, 0, lat);
        chk("latency_b", lat, 529);
        chk("count_sat", int'(cnt_b), 15);
        chk("ovf_sat", int'(ovf_v[1]), 1);
        do_run(1, 3, lat);
        chk_rng("count_clamp", int'(cnt_b), 10, 12);
        chk("ovf_cleared", int'(ovf_v[1]), 0);

        // Reset in the middle of the gate window.
        @(negedge clk);
        start_v[0] = 1'b1; sel_v[0] = 2'd0;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (600) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_count", int'(cnt_a), 0);
        chk("rst_osc_div", int'(osc_v[0]), 0);
        #20;
        chk("rst_rings_stopped", int'(dut_a.w_tail), 15);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_run(0, 2, lat);
        chk_rng("count_after_rst", int'(cnt_a), 21, 23);

        // Randomised runs with ignored mid-run start pulses.
        for (int i = 0; i < 8; i++) begin
            int d;
            int sel;
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 20)) @(negedge clk);
            start_v[d] = 1'b1;
            sel_v[d]   = 2'(sel);
            @(negedge clk);
            start_v[d] = 1'b0;
            repeat ($urandom_range(20, 400)) @(negedge clk);
            start_v[d] = 1'b1;
            sel_v[d]   = 2'($urandom_range(0, 3));
            @(negedge clk);
            start_v[d] = 1'b0;
            wait_done(d, 1200, lat);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
